// File: rtl/seq_pkg.sv
// Shared definitions for the ROM-driven microsequencer.
//   ADDR_W_DEFAULT / WORD_W_DEFAULT : default control ROM address and word widths
//   state_t : sequencer FSM states
//   mode_t  : whether the FSM keeps fetching after an instruction retires
package seq_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int WORD_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_CONT   = 1'b1
  } mode_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter for the microsequencer.
//   clk, rst_n : clock, asynchronous active-low reset (PC clears to 0)
//   clear      : synchronous return to address 0 (restart from HALT)
//   done       : current instruction retired; PC advances this edge
//   jump       : qualified by done; load jump_addr instead of incrementing
//   jump_addr  : jump target
//   pc         : current PC, drives the ROM address
//   wrap       : one-cycle pulse following an increment from all-ones to 0
module pc_counter #(
  parameter int ADDR_W = seq_pkg::ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              done,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        pc <= '0;
      end else if (done) begin
        if (jump) begin
          // A jump that lands on 0 is not a rollover, so wrap stays low.
          pc <= jump_addr;
        end else begin
          pc   <= pc + 1'b1;
          wrap <= (pc == PC_MAX);
        end
      end
    end
  end

endmodule

// File: rtl/rom_sequencer.sv
// Control-ROM microsequencer: fetches a control word at the PC, presents it to
// the datapath until the datapath reports completion, then advances or jumps.
//   clk, rst_n    : clock, asynchronous active-low reset
//   run_i         : level; keep executing back-to-back while high
//   step_i        : pulse; execute a single instruction from IDLE
//   halt_i        : level; stop at the next instruction boundary
//   restart_i     : pulse; leave HALT with PC cleared to 0
//   rom_addr_o    : ROM address (the PC)
//   rom_data_i    : combinational ROM data for rom_addr_o
//   ctrl_word_o   : registered control word to the datapath
//   ctrl_valid_o  : ctrl_word_o is live (EXEC)
//   exec_done_i   : datapath finished the current control word
//   jump_i        : with exec_done_i, load PC from jump_addr_i
//   jump_addr_i   : jump target
//   wrap_o        : one-cycle pulse after PC rolls over from max to 0
//   halted_o      : FSM is in HALT
//   busy_o        : FSM is in FETCH or EXEC
module rom_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              halt_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [WORD_W-1:0] rom_data_i,
  output logic [WORD_W-1:0] ctrl_word_o,
  output logic              ctrl_valid_o,
  input  logic              exec_done_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              wrap_o,
  output logic              halted_o,
  output logic              busy_o
);

  state_t state;
  state_t state_next;
  mode_t  mode;

  logic   word_load;
  logic   instr_done;
  logic   pc_clear;
  logic   mode_load;
  mode_t  mode_value;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. halt_i wins over run/step both in IDLE and at the
  // instruction boundary; run_i dropping mid-instruction only matters at the
  // boundary, so an instruction in flight always retires.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when a branch leaves the state unchanged.
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (halt_i)       state_next = ST_HALT;
        else if (run_i)   state_next = ST_FETCH;
        else if (step_i)  state_next = ST_FETCH;
      end
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        if (exec_done_i) begin
          if (halt_i)                          state_next = ST_HALT;
          else if (mode == MODE_CONT && run_i) state_next = ST_FETCH;
          else                                 state_next = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (restart_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and strobe decode, all from the current state.
  always_comb begin
    ctrl_valid_o = 1'b0;
    busy_o       = 1'b0;
    halted_o     = 1'b0;
    word_load    = 1'b0;
    instr_done   = 1'b0;
    pc_clear     = 1'b0;
    mode_load    = 1'b0;
    mode_value   = MODE_SINGLE;
    unique case (state)
      ST_IDLE: begin
        // Mode is latched only when an instruction actually starts.
        mode_load  = !halt_i && (run_i || step_i);
        mode_value = run_i ? MODE_CONT : MODE_SINGLE;
      end
      ST_FETCH: begin
        busy_o    = 1'b1;
        word_load = 1'b1;
      end
      ST_EXEC: begin
        busy_o       = 1'b1;
        ctrl_valid_o = 1'b1;
        instr_done   = exec_done_i;
      end
      ST_HALT: begin
        halted_o = 1'b1;
        pc_clear = restart_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_SINGLE;
    end else if (mode_load) begin
      mode <= mode_value;
    end
  end

  // Control word is captured at the end of FETCH and then held untouched
  // through EXEC, so the datapath sees a stable word however long it takes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_word_o <= '0;
    end else if (word_load) begin
      ctrl_word_o <= rom_data_i;
    end
  end

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pc_clear),
    .done      (instr_done),
    .jump      (jump_i),
    .jump_addr (jump_addr_i),
    .pc        (rom_addr_o),
    .wrap      (wrap_o)
  );

endmodule

// File: tb/tb_rom_sequencer.sv
module tb_rom_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_i, step_i, halt_i, restart_i;
  logic [3:0] rom_addr_o;
  logic [9:0] rom_data_i;
  logic [9:0] ctrl_word_o;
  logic       ctrl_valid_o;
  logic       exec_done_i, jump_i;
  logic [3:0] jump_addr_i;
  logic       wrap_o, halted_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  // Hand-written control ROM contents; no entry is zero so the reset word is
  // distinguishable from any fetched word.
  logic [9:0] rom [16] = '{
    10'h3A1, 10'h05C, 10'h2F0, 10'h10F, 10'h1E3, 10'h27A, 10'h0B6, 10'h34D,
    10'h0C9, 10'h392, 10'h15B, 10'h2E4, 10'h07D, 10'h368, 10'h1A7, 10'h2D0
  };

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk = ~clk;

  rom_sequencer #(
    .ADDR_W (4),
    .WORD_W (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run_i),
    .step_i       (step_i),
    .halt_i       (halt_i),
    .restart_i    (restart_i),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .ctrl_word_o  (ctrl_word_o),
    .ctrl_valid_o (ctrl_valid_o),
    .exec_done_i  (exec_done_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .wrap_o       (wrap_o),
    .halted_o     (halted_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run_i = 1'b0; step_i = 1'b0; halt_i = 1'b0; restart_i = 1'b0;
    exec_done_i = 1'b0; jump_i = 1'b0; jump_addr_i = 4'd0;

    // Reset state.
    #3;
    check("rst_addr",  16'(rom_addr_o),   16'h0);
    check("rst_word",  16'(ctrl_word_o),  16'h0);
    check("rst_valid", 16'(ctrl_valid_o), 16'h0);
    check("rst_wrap",  16'(wrap_o),       16'h0);
    check("rst_busy",  16'(busy_o),       16'h0);
    check("rst_halt",  16'(halted_o),     16'h0);
    #9;
    rst_n = 1'b1;

    // Continuous run with exec_done tied high: 2 cycles per address.
    run_i = 1'b1; exec_done_i = 1'b1;
    for (int a = 0; a < 16; a++) begin
      tick();  // FETCH
      check($sformatf("run_fetch_addr%0d", a), 16'(rom_addr_o), 16'(a));
      check($sformatf("run_fetch_valid%0d", a), 16'(ctrl_valid_o), 16'h0);
      check($sformatf("run_fetch_busy%0d", a), 16'(busy_o), 16'h1);
      if (a > 0) check($sformatf("run_nowrap%0d", a), 16'(wrap_o), 16'h0);
      tick();  // EXEC
      check($sformatf("run_exec_valid%0d", a), 16'(ctrl_valid_o), 16'h1);
      check($sformatf("run_exec_word%0d", a), 16'(ctrl_word_o), 16'(rom[a]));
    end
    tick();  // FETCH of address 0 after rollover
    check("rollover_addr", 16'(rom_addr_o), 16'h0);
    check("rollover_wrap", 16'(wrap_o), 16'h1);
    tick();  // EXEC 0
    check("rollover_wrap_drop", 16'(wrap_o), 16'h0);

    // Walk to PC 5 and jump back to 0: no wrap pulse.
    for (int a = 1; a <= 5; a++) begin
      tick();
      tick();
    end
    check("pre_jump_addr", 16'(rom_addr_o), 16'h5);
    jump_i = 1'b1; jump_addr_i = 4'd0;
    tick();
    jump_i = 1'b0;
    check("jump0_addr", 16'(rom_addr_o), 16'h0);
    check("jump0_wrap", 16'(wrap_o), 16'h0);
    tick();  // EXEC 0
    check("jump0_wrap_late", 16'(wrap_o), 16'h0);
    check("jump0_word", 16'(ctrl_word_o), 16'(rom[0]));

    // Dropping run_i mid-EXEC finishes the instruction then goes IDLE.
    run_i = 1'b0;
    tick();
    check("stop_busy", 16'(busy_o), 16'h0);
    check("stop_addr", 16'(rom_addr_o), 16'h1);

    // Reset again so single-step starts from PC 0.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exec_done_i = 1'b0;
    step_i = 1'b1;
    tick();  // FETCH
    step_i = 1'b0;
    check("step_fetch_busy", 16'(busy_o), 16'h1);
    check("step_fetch_valid", 16'(ctrl_valid_o), 16'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("step_exec_valid%0d", c), 16'(ctrl_valid_o), 16'h1);
      check($sformatf("step_exec_word%0d", c), 16'(ctrl_word_o), 16'(rom[0]));
      if (c == 2) step_i = 1'b1;  // ignored outside IDLE
      else step_i = 1'b0;
    end
    exec_done_i = 1'b1;
    tick();
    exec_done_i = 1'b0;
    check("step_idle_valid", 16'(ctrl_valid_o), 16'h0);
    check("step_idle_busy", 16'(busy_o), 16'h0);
    check("step_pc", 16'(rom_addr_o), 16'h1);
    tick();
    check("step_stays_idle", 16'(busy_o), 16'h0);
    check("step_stays_pc", 16'(rom_addr_o), 16'h1);

    // Run from PC 1 to PC 4, then jump to 12.
    run_i = 1'b1; exec_done_i = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      tick();
      tick();
    end
    check("pc4_word", 16'(ctrl_word_o), 16'(rom[4]));
    exec_done_i = 1'b0; jump_i = 1'b1; jump_addr_i = 4'd12;
    tick();  // jump without done is ignored
    check("jump_nodone_addr", 16'(rom_addr_o), 16'h4);
    check("jump_nodone_valid", 16'(ctrl_valid_o), 16'h1);
    exec_done_i = 1'b1;
    tick();
    jump_i = 1'b0;
    check("jump12_addr", 16'(rom_addr_o), 16'd12);
    tick();  // EXEC 12
    check("jump12_word", 16'(ctrl_word_o), 16'(rom[12]));

    // halt_i mid-EXEC: instruction completes, then HALT.
    exec_done_i = 1'b0; halt_i = 1'b1;
    tick();
    check("halt_still_exec", 16'(ctrl_valid_o), 16'h1);
    exec_done_i = 1'b1;
    tick();
    halt_i = 1'b0; exec_done_i = 1'b0;
    check("halt_halted", 16'(halted_o), 16'h1);
    check("halt_busy", 16'(busy_o), 16'h0);
    check("halt_pc", 16'(rom_addr_o), 16'd13);
    tick();
    check("halt_ignores_run", 16'(halted_o), 16'h1);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    check("halt_ignores_step", 16'(halted_o), 16'h1);
    run_i = 1'b0; restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    check("restart_halted", 16'(halted_o), 16'h0);
    check("restart_busy", 16'(busy_o), 16'h0);
    check("restart_pc", 16'(rom_addr_o), 16'h0);

    // halt_i wins over run_i in IDLE.
    halt_i = 1'b1; run_i = 1'b1;
    tick();
    halt_i = 1'b0; run_i = 1'b0;
    check("idle_halt_prio", 16'(halted_o), 16'h1);
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    check("idle_halt_restart", 16'(halted_o), 16'h0);

    // Reset mid-EXEC at PC 7 clears outputs without a clock edge.
    run_i = 1'b1; exec_done_i = 1'b1;
    for (int a = 0; a < 7; a++) begin
      tick();
      tick();
    end
    tick();  // FETCH 7
    exec_done_i = 1'b0;
    tick();  // EXEC 7
    check("pc7_addr", 16'(rom_addr_o), 16'h7);
    check("pc7_valid", 16'(ctrl_valid_o), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(ctrl_valid_o), 16'h0);
    check("async_rst_word", 16'(ctrl_word_o), 16'h0);
    check("async_rst_addr", 16'(rom_addr_o), 16'h0);
    check("async_rst_busy", 16'(busy_o), 16'h0);
    exec_done_i = 1'b1;
    #3 rst_n = 1'b1;
    tick();  // FETCH 0
    check("post_rst_addr", 16'(rom_addr_o), 16'h0);
    check("post_rst_busy", 16'(busy_o), 16'h1);
    tick();  // EXEC 0
    check("post_rst_word", 16'(ctrl_word_o), 16'(rom[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
